// File: rtl/int_exec_pipe_pkg.sv
// -----------------------------------------------------------------------------
// int_exec_pipe_pkg
// Shared types and constants for the integer execution pipe:
//   - opcode constants (R_TYPE, I_TYPE, LUI_TYPE, BRANCH_TYPE)
//   - func3 / func7 constants for ALU and branch decode
//   - int_fifo_data : issued instruction (operands, tag, writeback flag)
//   - cdb_bfm       : common-data-bus result record
// -----------------------------------------------------------------------------
package int_exec_pipe_pkg;

  localparam int DATA_W = 32;  // operand field width; XLEN must not exceed it
  localparam int TAG_W  = 6;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] LUI_TYPE    = 7'b0110111;
  localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              wb_valid;
  } int_fifo_data;

  typedef struct packed {
    logic [DATA_W-1:0] cdb_result;
    logic [TAG_W-1:0]  cdb_tag;
    logic              cdb_valid;
    logic              cdb_branch;
    logic              cdb_branch_taken;
  } cdb_bfm;

  // An entry is worth broadcasting only if it writes a register or resolves a branch.
  function automatic logic entry_is_visible(cdb_bfm e);
    return e.cdb_valid | e.cdb_branch;
  endfunction

endpackage

// File: rtl/int_exec_pipe_fifo.sv
// -----------------------------------------------------------------------------
// cdb_out_fifo
// Small output queue holding CDB entries until the arbiter grants them.
// Ports: clk, rst (sync, active-high), flush (clears pointers), push/push_data,
//        pop, empty, full, head (all-zero when empty).
// Push and pop may occur in the same cycle, including when full.
// -----------------------------------------------------------------------------
module cdb_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_pop  = pop && !empty;
  // When full, the slot being popped this cycle is the one written.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/int_exec_pipe.sv
// -----------------------------------------------------------------------------
// int_exec_pipe
// Integer ALU / branch-resolve unit. The result is computed in the accept
// cycle, carried down a valid pipeline and written into an output queue that
// drives the CDB. A credit counter (occupancy) throttles issue so the queue
// can never overflow and the pipeline never stalls.
// Ports: clk, rst (sync, active-high), flush, issue_valid/issue_ready/
//        issue_data, cdb_req/cdb_grant/cdb_out, occupancy.
// Option macro: INT_EXEC_PIPE_SHIFT_EN enables the shift instructions;
//               without it shifts return 0 and no shifter is built.
// Timing: an entry accepted in cycle t is visible at the queue head in
//         cycle t+LATENCY (LATENCY-1 pipeline registers, then the queue).
// -----------------------------------------------------------------------------
module int_exec_pipe
  import int_exec_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  int_fifo_data                     issue_data,
  output logic                             cdb_req,
  input  logic                             cdb_grant,
  output cdb_bfm                           cdb_out,
  output logic [$clog2(OUT_DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(OUT_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(OUT_DEPTH);

  // ---------------- execute (accept cycle) ----------------
  logic [XLEN-1:0] op_a, op_b, alu_res, sll_res, srl_res, sra_res;
  logic            is_r, is_i, f7_base, f7_alt, r_ok, lt_s, lt_u, branch_taken;
  cdb_bfm          exec_entry;

  assign op_a    = issue_data.rs1_data[XLEN-1:0];
  assign op_b    = issue_data.rs2_data[XLEN-1:0];
  assign is_r    = (issue_data.opcode == R_TYPE);
  assign is_i    = (issue_data.opcode == I_TYPE);
  assign f7_base = (issue_data.func7 == F7_BASE);
  assign f7_alt  = (issue_data.func7 == F7_ALT);
  // I-type carries an immediate in func7's place, so it never invalidates the op.
  assign r_ok    = is_i || f7_base;
  assign lt_s    = $signed(op_a) < $signed(op_b);
  assign lt_u    = op_a < op_b;

`ifdef INT_EXEC_PIPE_SHIFT_EN
  logic [$clog2(XLEN)-1:0] shamt;
  assign shamt   = op_b[$clog2(XLEN)-1:0];
  assign sll_res = op_a << shamt;
  assign srl_res = op_a >> shamt;
  assign sra_res = $signed(op_a) >>> shamt;
`else
  assign sll_res = '0;
  assign srl_res = '0;
  assign sra_res = '0;
`endif

  always_comb begin
    alu_res = '0;
    case (issue_data.func3)
      F3_ADD_SUB: begin
        if (r_ok)        alu_res = op_a + op_b;
        else if (f7_alt) alu_res = op_a - op_b;
      end
      F3_SLL:  if (r_ok) alu_res = sll_res;
      F3_SLT:  if (r_ok) alu_res = {{(XLEN-1){1'b0}}, lt_s};
      F3_SLTU: if (r_ok) alu_res = {{(XLEN-1){1'b0}}, lt_u};
      F3_XOR:  if (r_ok) alu_res = op_a ^ op_b;
      F3_SRL_SRA: begin
        if (is_i)         alu_res = issue_data.func7[5] ? sra_res : srl_res;
        else if (f7_base) alu_res = srl_res;
        else if (f7_alt)  alu_res = sra_res;
      end
      F3_OR:   if (r_ok) alu_res = op_a | op_b;
      F3_AND:  if (r_ok) alu_res = op_a & op_b;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (issue_data.func3)
      F3_BEQ:  branch_taken = (op_a == op_b);
      F3_BNE:  branch_taken = (op_a != op_b);
      F3_BLT:  branch_taken = lt_s;
      F3_BGE:  branch_taken = !lt_s;
      F3_BLTU: branch_taken = lt_u;
      F3_BGEU: branch_taken = !lt_u;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    exec_entry = '0;
    if (issue_data.opcode == BRANCH_TYPE) begin
      exec_entry.cdb_branch       = 1'b1;
      exec_entry.cdb_branch_taken = branch_taken;
    end else begin
      exec_entry.cdb_tag   = issue_data.rd_tag;
      exec_entry.cdb_valid = issue_data.wb_valid;
      if (is_r || is_i)                         exec_entry.cdb_result = DATA_W'(alu_res);
      else if (issue_data.opcode == LUI_TYPE)   exec_entry.cdb_result = DATA_W'(op_b);
    end
  end

  // ---------------- handshake / credits ----------------
  logic       accept, pop_fire, fifo_empty, fifo_full;
  logic       wr_valid, wr_keep, wr_drop;
  cdb_bfm     wr_data, fifo_head;
  logic [OCC_W-1:0] occ_reg;

  assign cdb_req     = !fifo_empty;
  assign cdb_out     = fifo_head;
  assign pop_fire    = cdb_req && cdb_grant;
  assign issue_ready = (occ_reg < OCC_FULL) || pop_fire;
  assign accept      = issue_valid && issue_ready;
  assign occupancy   = occ_reg;

  // ---------------- valid pipeline ----------------
  generate
    if (LATENCY == 1) begin : g_direct
      assign wr_valid = accept;
      assign wr_data  = exec_entry;
    end else begin : g_pipe
      logic [LATENCY-2:0] valid_reg;
      cdb_bfm             data_reg [LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          valid_reg <= '0;
        end else begin
          valid_reg[0] <= accept;
          for (int i = 1; i < LATENCY - 1; i++) valid_reg[i] <= valid_reg[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_reg[0] <= exec_entry;
        for (int i = 1; i < LATENCY - 1; i++) data_reg[i] <= data_reg[i-1];
      end

      assign wr_valid = valid_reg[LATENCY-2];
      assign wr_data  = data_reg[LATENCY-2];
    end
  endgenerate

  assign wr_keep = wr_valid && entry_is_visible(wr_data);
  // Invisible entries never enter the queue; their credit returns on the write cycle.
  assign wr_drop = wr_valid && !entry_is_visible(wr_data);

  always_ff @(posedge clk) begin
    if (rst || flush) occ_reg <= '0;
    else occ_reg <= occ_reg + OCC_W'(accept) - OCC_W'(pop_fire) - OCC_W'(wr_drop);
  end

  cdb_out_fifo #(
    .WIDTH ($bits(cdb_bfm)),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (wr_keep && (!fifo_full || pop_fire)),
    .push_data (wr_data),
    .pop       (pop_fire),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_int_exec_pipe.sv
`timescale 1ns/1ps
module tb_int_exec_pipe;
  import int_exec_pipe_pkg::*;

  localparam int XLEN = 32, LAT = 2, DEP = 2, OCC_W = $clog2(DEP + 1);

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, issue_valid = 1'b0, cdb_grant = 1'b0;
  logic issue_ready, cdb_req;
  int_fifo_data issue_data = '0;
  cdb_bfm cdb_out;
  logic [OCC_W-1:0] occupancy;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  int_exec_pipe #(.XLEN(XLEN), .LATENCY(LAT), .OUT_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_data(issue_data), .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_out(cdb_out),
    .occupancy(occupancy));

  task automatic next_cycle(); @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); endtask

  function automatic int_fifo_data mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                      logic [31:0] a, logic [31:0] b, int tag, logic wb);
    int_fifo_data d;
    d = '0; d.opcode = op; d.func3 = f3; d.func7 = f7; d.rs1_data = a; d.rs2_data = b;
    d.rd_tag = TAG_W'(tag); d.wb_valid = wb;
    return d;
  endfunction

  // Reference: results derived directly from the instruction-set rules.
  function automatic cdb_bfm ref_exec(int_fifo_data d);
    cdb_bfm r;
    logic [31:0] a, b, res;
    int sh;
    bit shift_en, is_r, alt, f7ok, t;
    r = '0; a = d.rs1_data; b = d.rs2_data; res = 0; sh = int'(b[4:0]);
`ifdef INT_EXEC_PIPE_SHIFT_EN
    shift_en = 1;
`else
    shift_en = 0;
`endif
    if (d.opcode == BRANCH_TYPE) begin
      t = 0;
      if (d.func3 == 0) t = (a == b);
      if (d.func3 == 1) t = (a != b);
      if (d.func3 == 4) t = ($signed(a) < $signed(b));
      if (d.func3 == 5) t = ($signed(a) >= $signed(b));
      if (d.func3 == 6) t = (a < b);
      if (d.func3 == 7) t = (a >= b);
      r.cdb_branch = 1; r.cdb_branch_taken = t;
      return r;
    end
    r.cdb_tag = d.rd_tag; r.cdb_valid = d.wb_valid;
    if (d.opcode == LUI_TYPE) res = b;
    else if (d.opcode == R_TYPE || d.opcode == I_TYPE) begin
      is_r = (d.opcode == R_TYPE);
      alt  = (d.func7 == 7'h20);
      f7ok = (d.func7 == 7'h00) || (alt && (d.func3 == 0 || d.func3 == 5));
      if (is_r && !f7ok) res = 0;
      else if (d.func3 == 0) res = (is_r && alt) ? a - b : a + b;
      else if (d.func3 == 1) res = shift_en ? a << sh : 0;
      else if (d.func3 == 2) res = ($signed(a) < $signed(b)) ? 1 : 0;
      else if (d.func3 == 3) res = (a < b) ? 1 : 0;
      else if (d.func3 == 4) res = a ^ b;
      else if (d.func3 == 6) res = a | b;
      else if (d.func3 == 7) res = a & b;
      else if (shift_en) begin
        res = a >> sh;
        if (((is_r && alt) || (!is_r && d.func7[5])) && a[31])
          for (int k = 0; k < sh; k++) res[31-k] = 1'b1;
      end
    end
    r.cdb_result = res;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1; flush = 1; issue_valid = 1; cdb_grant = 1;
    issue_data = mk(R_TYPE, F3_ADD_SUB, F7_BASE, 1, 2, 1, 1);
    repeat (3) @(posedge clk);
    #1; rst = 0; flush = 0; issue_valid = 0; cdb_grant = 0;
    sample();
    checks++; if (occupancy !== 0) $display("FAIL reset_occ: got %0d want 0", occupancy); else passed++;
    checks++; if (cdb_req !== 0) $display("FAIL reset_req: got %b want 0", cdb_req); else passed++;
    checks++; if (cdb_out !== '0) $display("FAIL reset_out: got %h want 0", cdb_out); else passed++;
    checks++; if (issue_ready !== 1) $display("FAIL reset_ready: got %b want 1", issue_ready); else passed++;
    $display("reset: occ=%0d req=%b ready=%b", occupancy, cdb_req, issue_ready);
  endtask

  task automatic test_add();
    cdb_grant = 1;
    next_cycle(); issue_valid = 1; issue_data = mk(R_TYPE, F3_ADD_SUB, F7_BASE, 5, 7, 3, 1);
    sample();
    checks++; if (issue_ready !== 1) $display("FAIL add_ready: got %b want 1", issue_ready); else passed++;
    next_cycle(); issue_valid = 0; sample();
    checks++; if (cdb_req !== 0) $display("FAIL add_req_early: got %b want 0", cdb_req); else passed++;
    checks++; if (occupancy !== 1) $display("FAIL add_occ_inflight: got %0d want 1", occupancy); else passed++;
    next_cycle(); sample();
    $display("add: req=%b result=%0d tag=%0d valid=%b", cdb_req, cdb_out.cdb_result, cdb_out.cdb_tag, cdb_out.cdb_valid);
    checks++; if (cdb_req !== 1) $display("FAIL add_req: got %b want 1", cdb_req); else passed++;
    checks++; if (cdb_out.cdb_result !== 32'd12) $display("FAIL add_result: got %0d want 12", cdb_out.cdb_result); else passed++;
    checks++; if (cdb_out.cdb_tag !== 3) $display("FAIL add_tag: got %0d want 3", cdb_out.cdb_tag); else passed++;
    checks++; if (cdb_out.cdb_valid !== 1 || cdb_out.cdb_branch !== 0) $display("FAIL add_flags: got v=%b br=%b want v=1 br=0", cdb_out.cdb_valid, cdb_out.cdb_branch); else passed++;
    next_cycle(); sample();
    checks++; if (cdb_req !== 0 || occupancy !== 0) $display("FAIL add_drain: got req=%b occ=%0d want 0/0", cdb_req, occupancy); else passed++;
  endtask

  task automatic test_branch();
    cdb_bfm exp_t, exp_n;
    exp_t = '0; exp_t.cdb_branch = 1; exp_t.cdb_branch_taken = 1;
    exp_n = '0; exp_n.cdb_branch = 1;
    cdb_grant = 1;
    next_cycle(); issue_valid = 1; issue_data = mk(BRANCH_TYPE, F3_BLTU, F7_BASE, 1, 32'hFFFF_FFFF, 5, 1);
    next_cycle(); issue_data = mk(BRANCH_TYPE, F3_BLT, F7_BASE, 1, 32'hFFFF_FFFF, 6, 1);
    next_cycle(); issue_valid = 0; sample();
    $display("bltu: req=%b out=%h", cdb_req, cdb_out);
    checks++; if (cdb_req !== 1 || cdb_out !== exp_t) $display("FAIL bltu_out: got req=%b %h want 1 %h", cdb_req, cdb_out, exp_t); else passed++;
    next_cycle(); sample();
    $display("blt: req=%b out=%h", cdb_req, cdb_out);
    checks++; if (cdb_req !== 1 || cdb_out !== exp_n) $display("FAIL blt_out: got req=%b %h want 1 %h", cdb_req, cdb_out, exp_n); else passed++;
    next_cycle(); sample();
    checks++; if (cdb_req !== 0) $display("FAIL branch_drain: got %b want 0", cdb_req); else passed++;
  endtask

  task automatic test_back_to_back();
    cdb_grant = 0;
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); issue_valid = 1; issue_data = mk(R_TYPE, F3_ADD_SUB, F7_BASE, 32'(i), 32'(i), i, 1);
    end
    sample();
    checks++; if (issue_ready !== 0) $display("FAIL bp_ready_full: got %b want 0", issue_ready); else passed++;
    checks++; if (occupancy !== 2) $display("FAIL bp_occ_full: got %0d want 2", occupancy); else passed++;
    next_cycle(); sample();
    checks++; if (issue_ready !== 0) $display("FAIL bp_ready_hold: got %b want 0", issue_ready); else passed++;
    next_cycle(); cdb_grant = 1; sample();
    checks++; if (issue_ready !== 1) $display("FAIL bp_ready_grant: got %b want 1", issue_ready); else passed++;
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) begin next_cycle(); issue_valid = 0; sample(); end
      $display("bp pop: tag=%0d result=%0d", cdb_out.cdb_tag, cdb_out.cdb_result);
      checks++; if (cdb_req !== 1 || cdb_out.cdb_tag !== TAG_W'(i) || cdb_out.cdb_result !== 32'(2*i))
        $display("FAIL bp_order%0d: got req=%b tag=%0d res=%0d want 1 %0d %0d", i, cdb_req, cdb_out.cdb_tag, cdb_out.cdb_result, i, 2*i);
      else passed++;
    end
    next_cycle(); cdb_grant = 0; sample();
    checks++; if (cdb_req !== 0 || occupancy !== 0) $display("FAIL bp_drain: got req=%b occ=%0d want 0/0", cdb_req, occupancy); else passed++;
  endtask

  task automatic test_flush();
    cdb_grant = 0;
    next_cycle(); issue_valid = 1; issue_data = mk(I_TYPE, F3_ADD_SUB, F7_BASE, 10, 20, 1, 1);
    next_cycle(); issue_data = mk(I_TYPE, F3_ADD_SUB, F7_BASE, 11, 20, 2, 1); flush = 1;
    next_cycle(); issue_valid = 0; flush = 0; sample();
    $display("flush: occ=%0d req=%b ready=%b", occupancy, cdb_req, issue_ready);
    checks++; if (occupancy !== 0) $display("FAIL flush_occ: got %0d want 0", occupancy); else passed++;
    checks++; if (issue_ready !== 1) $display("FAIL flush_ready: got %b want 1", issue_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (cdb_req !== 0) $display("FAIL flush_req%0d: got %b want 0", i, cdb_req); else passed++;
      next_cycle(); sample();
    end
  endtask

  task automatic test_shift();
    logic [31:0] exp_sra, exp_srli;
`ifdef INT_EXEC_PIPE_SHIFT_EN
    exp_sra = 32'hF800_0000; exp_srli = 32'h0800_0000;
`else
    exp_sra = 32'h0; exp_srli = 32'h0;
`endif
    cdb_grant = 1;
    next_cycle(); issue_valid = 1; issue_data = mk(R_TYPE, F3_SRL_SRA, F7_ALT, 32'h8000_0000, 4, 4, 1);
    next_cycle(); issue_data = mk(I_TYPE, F3_SRL_SRA, F7_BASE, 32'h8000_0000, 4, 6, 1);
    next_cycle(); issue_valid = 0; sample();
    $display("sra: result=%h tag=%0d valid=%b", cdb_out.cdb_result, cdb_out.cdb_tag, cdb_out.cdb_valid);
    checks++; if (cdb_out.cdb_result !== exp_sra) $display("FAIL sra_result: got %h want %h", cdb_out.cdb_result, exp_sra); else passed++;
    checks++; if (cdb_out.cdb_valid !== 1 || cdb_out.cdb_tag !== 4) $display("FAIL sra_tag: got v=%b tag=%0d want 1 4", cdb_out.cdb_valid, cdb_out.cdb_tag); else passed++;
    next_cycle(); sample();
    $display("srli: result=%h tag=%0d", cdb_out.cdb_result, cdb_out.cdb_tag);
    checks++; if (cdb_out.cdb_result !== exp_srli || cdb_out.cdb_tag !== 6) $display("FAIL srli_result: got %h tag %0d want %h 6", cdb_out.cdb_result, cdb_out.cdb_tag, exp_srli); else passed++;
    next_cycle(); sample();
  endtask

  task automatic test_drop();
    cdb_grant = 1;
    next_cycle(); issue_valid = 1; issue_data = mk(I_TYPE, F3_ADD_SUB, F7_BASE, 1, 1, 2, 0);
    next_cycle(); issue_data = mk(R_TYPE, F3_XOR, F7_BASE, 32'hF0, 32'h0F, 9, 1);
    next_cycle(); issue_valid = 0; sample();
    checks++; if (cdb_req !== 0) $display("FAIL drop_no_output: got req=%b want 0", cdb_req); else passed++;
    checks++; if (occupancy !== 1) $display("FAIL drop_credit: got %0d want 1", occupancy); else passed++;
    next_cycle(); sample();
    $display("xor: result=%h tag=%0d", cdb_out.cdb_result, cdb_out.cdb_tag);
    checks++; if (cdb_req !== 1 || cdb_out.cdb_result !== 32'hFF || cdb_out.cdb_tag !== 9)
      $display("FAIL drop_xor: got req=%b res=%h tag=%0d want 1 ff 9", cdb_req, cdb_out.cdb_result, cdb_out.cdb_tag); else passed++;
    next_cycle(); sample();
    checks++; if (cdb_req !== 0 || occupancy !== 0) $display("FAIL drop_drain: got req=%b occ=%0d want 0/0", cdb_req, occupancy); else passed++;
  endtask

  task automatic test_reset_mid();
    cdb_grant = 0;
    next_cycle(); issue_valid = 1; issue_data = mk(LUI_TYPE, 0, 0, 0, 32'h1234_5000, 7, 1);
    next_cycle(); issue_data = mk(LUI_TYPE, 0, 0, 0, 32'h5678_9000, 8, 1);
    next_cycle(); issue_valid = 0; rst = 1; sample();
    checks++; if (cdb_req !== 1 || cdb_out.cdb_result !== 32'h1234_5000) $display("FAIL midrst_pre: got req=%b res=%h want 1 12345000", cdb_req, cdb_out.cdb_result); else passed++;
    next_cycle(); rst = 0; sample();
    $display("mid reset: occ=%0d req=%b ready=%b", occupancy, cdb_req, issue_ready);
    checks++; if (occupancy !== 0 || issue_ready !== 1) $display("FAIL midrst_state: got occ=%0d ready=%b want 0 1", occupancy, issue_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (cdb_req !== 0) $display("FAIL midrst_req%0d: got %b want 0", i, cdb_req); else passed++;
      next_cycle(); sample();
    end
  endtask

  function automatic int_fifo_data rand_instr();
    int_fifo_data d;
    d = '0;
    case ($urandom_range(0, 5))
      0, 1: d.opcode = R_TYPE;
      2:    d.opcode = I_TYPE;
      3:    d.opcode = LUI_TYPE;
      4:    d.opcode = BRANCH_TYPE;
      default: d.opcode = 7'h03;
    endcase
    d.func3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0, 1: d.func7 = 7'h00;
      2:    d.func7 = 7'h20;
      default: d.func7 = 7'($urandom);
    endcase
    d.rs1_data = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
    d.rs2_data = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
    d.rd_tag   = TAG_W'($urandom);
    d.wb_valid = ($urandom_range(0, 4) != 0);
    return d;
  endfunction

  typedef struct { cdb_bfm e; int age; } flight_t;

  task automatic test_random();
    flight_t inflight[$];
    cdb_bfm outq[$];
    cdb_bfm exp_head, e;
    int exp_occ, npop;
    logic exp_req, exp_ready;
    npop = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      next_cycle();
      flush = ($urandom_range(0, 39) == 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_data = rand_instr();
      cdb_grant = ($urandom_range(0, 2) != 0);
      sample();
      exp_occ   = inflight.size() + outq.size();
      exp_req   = (outq.size() > 0);
      exp_head  = exp_req ? outq[0] : '0;
      exp_ready = (exp_occ < DEP) || (exp_req && cdb_grant);
      checks++; if (occupancy !== OCC_W'(exp_occ)) $display("FAIL rnd_occ c%0d: got %0d want %0d", cyc, occupancy, exp_occ); else passed++;
      checks++; if (cdb_req !== exp_req) $display("FAIL rnd_req c%0d: got %b want %b", cyc, cdb_req, exp_req); else passed++;
      checks++; if (cdb_out !== exp_head) $display("FAIL rnd_out c%0d: got %h want %h", cyc, cdb_out, exp_head); else passed++;
      checks++; if (issue_ready !== exp_ready) $display("FAIL rnd_ready c%0d: got %b want %b", cyc, issue_ready, exp_ready); else passed++;
      if (flush) begin
        inflight.delete(); outq.delete();
      end else begin
        if (exp_req && cdb_grant) begin
          npop++;
          $display("rnd pop %0d: result=%h tag=%0d v=%b br=%b tk=%b", npop, outq[0].cdb_result,
                   outq[0].cdb_tag, outq[0].cdb_valid, outq[0].cdb_branch, outq[0].cdb_branch_taken);
          void'(outq.pop_front());
        end
        foreach (inflight[i]) inflight[i].age++;
        if (issue_valid && exp_ready) inflight.push_back('{e: ref_exec(issue_data), age: 1});
        while (inflight.size() > 0 && inflight[0].age >= LAT) begin
          e = inflight[0].e;
          void'(inflight.pop_front());
          if (e.cdb_valid || e.cdb_branch) outq.push_back(e);
        end
      end
    end
    next_cycle(); issue_valid = 0; flush = 0; cdb_grant = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_back_to_back();
    test_flush();
    test_shift();
    test_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/int_exec_pipe.md
INT_EXEC_PIPE -- requirements
Module: int_exec_pipe

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Parameter LATENCY, default 2, legal 1..4: cycles from issue accept to output-queue write.
REQ-003 Parameter OUT_DEPTH, default 2, legal 1..8: output queue entries.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port flush  input  1  discard all in-flight and queued work.
REQ-007 Port issue_valid  input  1  issue_data holds an instruction.
REQ-008 Port issue_ready  output  1  unit accepts this cycle.
REQ-009 Port issue_data  input  int_fifo_data  opcode, func3, func7, rs1_data, rs2_data, rd_tag, wb_valid.
REQ-010 Port cdb_req  output  1  queue head is ready for the CDB.
REQ-011 Port cdb_grant  input  1  arbiter takes cdb_out this cycle.
REQ-012 Port cdb_out  output  cdb_bfm  queue head: cdb_result, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken.
REQ-013 Port occupancy  output  $clog2(OUT_DEPTH+1)  in-flight plus queued entries.

Function
REQ-014 Accept SHALL occur when issue_valid and issue_ready are both high; the result is computed in the accept cycle and carried through a LATENCY-stage valid pipeline.
REQ-015 issue_ready SHALL be high iff occupancy < OUT_DEPTH, or a pop occurs in the same cycle (credit scheme); the pipeline never stalls and the queue never overflows.
REQ-016 Accept with pop in the same cycle SHALL leave occupancy unchanged; accept alone +1; pop alone -1.
REQ-017 R_TYPE: func3 0 add (func7 0x00) / sub (func7 0x20), 1 sll, 2 slt signed, 3 sltu, 4 xor, 5 srl (func7 0x00) / sra (func7 0x20), 6 or, 7 and; any other func7 yields result 0.
REQ-018 I_TYPE: same func3 map with rs2_data as immediate; func3 0 is always add; func3 5 selects srl/sra by func7 bit 5.
REQ-019 Shift amount SHALL be rs2_data[$clog2(XLEN)-1:0]; all arithmetic wraps modulo 2^XLEN.
REQ-020 LUI_TYPE: result = rs2_data; other non-branch opcodes: result 0.
REQ-021 Non-branch: cdb_tag = rd_tag, cdb_valid = wb_valid, cdb_branch = 0, cdb_branch_taken = 0.
REQ-022 BRANCH_TYPE: func3 0 beq, 1 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu, others not taken; cdb_branch = 1, cdb_valid = 0, cdb_tag = 0, cdb_result = 0.
REQ-023 Entries with cdb_valid = 0 and cdb_branch = 0 SHALL NOT be written to the queue; their credit is released on the write cycle.
REQ-024 cdb_req SHALL equal queue non-empty; cdb_out SHALL be the head, all-zero when empty; pop on cdb_req and cdb_grant.
REQ-025 Queue write and pop SHALL be simultaneous-capable, including when full (write-through of freed slot not required; credit prevents it).
REQ-026 flush SHALL clear pipeline valids, queue pointers and occupancy in the next cycle; an accept or grant in the flush cycle is discarded; flush has priority over all other events.
REQ-027 Order on the CDB SHALL equal issue order.

Reset
REQ-028 rst SHALL have priority over flush; after reset: occupancy 0, cdb_req 0, cdb_out all-zero, issue_ready 1, pipeline valids 0.
REQ-029 Reset asserted mid-operation SHALL discard all work on the same edge; no partial entry is emitted afterwards.

Configuration
REQ-030 Macro INT_EXEC_PIPE_SHIFT_EN defined: sll/srl/sra/slli/srli/srai implemented per REQ-017..019.
REQ-031 Macro undefined: shift func3 values (1, 5) produce result 0 with tag/valid per REQ-021; no barrel shifter is synthesised.

Structure
REQ-032 cdb_bfm, int_fifo_data, opcode constants (R_TYPE, I_TYPE, LUI_TYPE, BRANCH_TYPE) and func3/func7 constants SHALL live in the shared utils package.
REQ-033 The output queue SHALL be a separate sub-module cdb_out_fifo (parameters WIDTH, DEPTH; push, pop, flush, empty, full, head).

Verification (LATENCY=2, OUT_DEPTH=2, XLEN=32)
REQ-034 Issue add rs1=5 rs2=7 tag 3 wb_valid 1, grant held high -> cdb_req high 2 cycles later, cdb_result 12, cdb_tag 3, cdb_valid 1.
REQ-035 Issue bltu rs1=1 rs2=0xFFFFFFFF then blt same operands -> two outputs cdb_branch 1, taken 1 then 0, cdb_valid 0.
REQ-036 Grant held low, issue 3 back-to-back -> third cycle issue_ready 0, occupancy 2; grant one cycle -> issue_ready 1 same cycle, order preserved.
REQ-037 Issue 2 instructions, flush one cycle later -> next cycle occupancy 0, cdb_req stays 0, issue_ready 1.
REQ-038 With macro defined, sra rs1=0x80000000 rs2=4 -> 0xF8000000; without macro -> result 0, cdb_valid 1.
REQ-039 Issue addi wb_valid 0 then xor 0xF0^0x0F tag 9 -> only one CDB output, result 0xFF, tag 9; occupancy returns to 0.
